// File: rtl/uart_fifo_tx_if.sv
// FIFO-read and serial-line signals of the UART transmitter.
// master: the transmitter (drives RD and the line); slave: the FIFO side.
interface uart_fifo_tx_if;
  logic       EMPTY;
  logic [7:0] dataIn;
  logic       RD;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    input  EMPTY,
    input  dataIn,
    output RD,
    output tx,
    output busy,
    output tx_done
  );

  modport slave (
    output EMPTY,
    output dataIn,
    input  RD,
    input  tx,
    input  busy,
    input  tx_done
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter: drains a byte FIFO and sends each byte as an 8N1/8N2
// frame, LSB first. One RD strobe per byte, data captured the cycle after.
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart_fifo_tx_if.master bus
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             done_reg, done_next;
  logic             bit_end;
  logic [7:0]       shift_dn;

  // Terminal count of the baud counter closes the current bit period.
  assign bit_end = (cnt_reg == CNT_LAST);

  // Shift register moved one place toward the LSB, zero filled at the top.
  for (genvar gi = 0; gi < 8; gi++) begin : g_shift
    if (gi == 7) begin : g_msb
      assign shift_dn[gi] = 1'b0;
    end else begin : g_bit
      assign shift_dn[gi] = shift_reg[gi+1];
    end
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  // Next-state decode: FETCH is a single cycle, bit periods end on bit_end.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!bus.EMPTY) state_next = FETCH;
      FETCH:   state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (idx_reg == 3'd7)) state_next = STOP;
      STOP:    if (bit_end && (idx_reg == STOP_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters, shift register and registered outputs for the coming cycle.
  always_comb begin
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
      end
      FETCH: begin
        shift_next = bus.dataIn;
        cnt_next   = '0;
        idx_next   = '0;
      end
      START: begin
        cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift_dn;
          // wraps 7 -> 0, so STOP starts counting stop bits from zero
          idx_next   = idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          idx_next = idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        cnt_next = '0;
        idx_next = '0;
      end
    endcase

    // Line level is derived from the state being entered so tx is a plain flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase

    done_next = (state_reg == STOP) && (state_next == IDLE);
  end

  // RD is gated by reset so the FIFO is never read while reset is held.
  assign bus.RD      = reset && (state_reg == IDLE) && !bus.EMPTY;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.tx      = tx_reg;
  assign bus.tx_done = done_reg;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Randomized scoreboard bench for uart_fifo_tx with C=4: instance 0 uses one
// stop bit, instance 1 two. Each instance has a FIFO model, a scoreboard of
// bytes read, and a line decoder checking frame contents and timing.
module tb_uart_fifo_tx;

  localparam int C = 4;

  typedef struct packed {
    logic [7:0] data;
    int         rd_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n [2];
  logic noise = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int S     = gi + 1;
    localparam int FRAME = (9 + S) * C;

    uart_fifo_tx_if bus ();

    uart_fifo_tx #(.CLKS_PER_BIT(C), .STOP_BITS(S)) dut (
      .clk   (clk),
      .reset (rst_n[gi]),
      .bus   (bus)
    );

    logic [7:0] fifo_q [$];
    exp_t       exp_q [$];
    int         rd_cycles [$];
    exp_t       cur;
    int         frames = 0;
    int         k = 0;
    int         j;
    bit         in_frame = 1'b0;
    bit         bit_bad = 1'b0;
    logic       bad_val = 1'b0;
    logic       exp_bit;
    logic       rd_q = 1'b0;
    logic [7:0] d;

    // RD as sampled by the DUT on this edge (read before state updates).
    always @(posedge clk) rd_q <= bus.RD;

    // Monitor first (sampling mid-cycle), then drive the FIFO side.
    always @(negedge clk) begin
      if (!rst_n[gi]) begin
        check({bus.tx, bus.RD, bus.busy, bus.tx_done} === 4'b1000, "reset_outputs",
              int'({bus.tx, bus.RD, bus.busy, bus.tx_done}), 8);
        in_frame = 1'b0;
        exp_q.delete();
      end else begin
        if (bus.RD === 1'b1)
          check(!bus.busy && !bus.EMPTY, "rd_outside_idle", int'({bus.busy, bus.EMPTY}), 0);
        if (!in_frame) begin
          check(bus.tx_done === 1'b0, "stray_tx_done", int'(bus.tx_done), 0);
          if (bus.tx === 1'b0) begin
            check(exp_q.size() != 0, "unexpected_start", 0, 1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              check(cyc == cur.rd_cyc + 2, "start_latency", cyc, cur.rd_cyc + 2);
              in_frame = 1'b1;
              k = 0;
              bit_bad = 1'b0;
            end
          end
        end
        if (in_frame) begin
          if (k < FRAME) begin
            j = k / C;
            if (j == 0)      exp_bit = 1'b0;
            else if (j <= 8) exp_bit = cur.data[j-1];
            else             exp_bit = 1'b1;
            if (bus.tx !== exp_bit) begin
              bit_bad = 1'b1;
              bad_val = bus.tx;
            end
            if ((k % C) == C - 1) begin
              check(!bit_bad, $sformatf("frame_bit%0d_byte%02h", j, cur.data),
                    int'(bit_bad ? bad_val : exp_bit), int'(exp_bit));
              bit_bad = 1'b0;
            end
            k++;
          end else begin
            check(bus.tx_done === 1'b1 && bus.busy === 1'b0, "tx_done_timing",
                  int'({bus.tx_done, bus.busy}), 2);
            frames++;
            in_frame = 1'b0;
          end
        end
      end

      if (rst_n[gi] && rd_q) begin
        check(fifo_q.size() != 0, "fifo_underflow", 0, 1);
        if (fifo_q.size() != 0) begin
          d = fifo_q.pop_front();
          bus.dataIn = d;
          exp_q.push_back('{data: d, rd_cyc: cyc - 1});
          rd_cycles.push_back(cyc - 1);
        end
      end else begin
        bus.dataIn = 8'($urandom);
      end
      if (noise && bus.busy === 1'b1) bus.EMPTY = 1'($urandom);
      else                            bus.EMPTY = (fifo_q.size() == 0);
    end
  end

  function automatic bit all_idle();
    return g_inst[0].fifo_q.size() == 0 && g_inst[0].exp_q.size() == 0 &&
           !g_inst[0].in_frame && g_inst[0].bus.busy === 1'b0 &&
           g_inst[1].fifo_q.size() == 0 && g_inst[1].exp_q.size() == 0 &&
           !g_inst[1].in_frame && g_inst[1].bus.busy === 1'b0;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(n < budget, "idle_timeout", n, budget);
  endtask

  task automatic wait_bit3();
    int n = 0;
    while (!(g_inst[0].in_frame && g_inst[0].k == 18) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check(n < 300, "bit3_timeout", n, 300);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    // bytes queued during reset keep EMPTY low while reset is held
    g_inst[0].fifo_q.push_back(8'hA5);
    g_inst[1].fifo_q.push_back(8'h81);
    g_inst[1].fifo_q.push_back(8'h3C);
    repeat (5) @(negedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // single byte, and two-stop-bit back-to-back pair
    wait_idle(400);
    check(g_inst[0].frames == 1, "single_frames", g_inst[0].frames, 1);
    check(g_inst[0].rd_cycles.size() == 1, "single_rd_count", g_inst[0].rd_cycles.size(), 1);
    check(g_inst[1].frames == 2, "s2_frames", g_inst[1].frames, 2);
    check(g_inst[1].rd_cycles[1] - g_inst[1].rd_cycles[0] == 46, "s2_period",
          g_inst[1].rd_cycles[1] - g_inst[1].rd_cycles[0], 46);

    // back-to-back with one stop bit
    g_inst[0].fifo_q.push_back(8'h00);
    g_inst[0].fifo_q.push_back(8'hFF);
    g_inst[0].fifo_q.push_back(8'h55);
    wait_idle(400);
    check(g_inst[0].frames == 4, "b2b_frames", g_inst[0].frames, 4);
    check(g_inst[0].rd_cycles.size() == 4, "b2b_rd_count", g_inst[0].rd_cycles.size(), 4);
    for (int i = 2; i < 4; i++)
      check(g_inst[0].rd_cycles[i] - g_inst[0].rd_cycles[i-1] == 42, "b2b_period",
            g_inst[0].rd_cycles[i] - g_inst[0].rd_cycles[i-1], 42);

    // random bytes with EMPTY/dataIn noise while busy
    noise = 1'b1;
    for (int i = 0; i < 6; i++) begin
      g_inst[0].fifo_q.push_back(8'($urandom));
      g_inst[1].fifo_q.push_back(8'($urandom));
      repeat ($urandom_range(60, 0)) @(negedge clk);
      #1;
    end
    wait_idle(2000);
    noise = 1'b0;
    check(g_inst[0].frames == 10, "noise_frames0", g_inst[0].frames, 10);
    check(g_inst[1].frames == 8, "noise_frames1", g_inst[1].frames, 8);

    // reset during data bit 3, released with the FIFO empty
    g_inst[0].fifo_q.push_back(8'h3C);
    wait_bit3();
    #2;
    rst_n[0] = 1'b0;
    #1;
    check(g_inst[0].bus.tx === 1'b1 && g_inst[0].bus.busy === 1'b0, "async_abort",
          int'({g_inst[0].bus.tx, g_inst[0].bus.busy}), 2);
    repeat (3) @(negedge clk);
    #1;
    rst_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check(g_inst[0].rd_cycles.size() == 11, "no_rd_after_release",
          g_inst[0].rd_cycles.size(), 11);
    check(g_inst[0].frames == 10, "aborted_not_counted", g_inst[0].frames, 10);

    // reset during data bit 3, released with the next byte waiting
    g_inst[0].fifo_q.push_back(8'h96);
    g_inst[0].fifo_q.push_back(8'h5A);
    wait_bit3();
    #2;
    rst_n[0] = 1'b0;
    #1;
    check(g_inst[0].bus.tx === 1'b1 && g_inst[0].bus.busy === 1'b0, "async_abort2",
          int'({g_inst[0].bus.tx, g_inst[0].bus.busy}), 2);
    @(negedge clk);
    #1;
    rst_n[0] = 1'b1;
    #1;
    check(g_inst[0].bus.RD === 1'b1, "rd_after_release", int'(g_inst[0].bus.RD), 1);
    @(negedge clk);
    #1;
    check(g_inst[0].bus.busy === 1'b1, "fetch_first_edge", int'(g_inst[0].bus.busy), 1);
    wait_idle(400);
    check(g_inst[0].frames == 11, "next_byte_sent", g_inst[0].frames, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
